// File: rtl/sbit_deadtime_oneshot.sv
// sbit_deadtime_oneshot: gates S-bits by alignment/mask, converts each channel to one-shot pulses with a deadtime, counts hit cycles (clock/reset_i in; sbits_i, aligned_i, mask_i, deadtime_i, hitcnt_clear_i in; sbits_o, active_o, hit_count_o out)
module sbit_deadtime_oneshot #(
  parameter int MXSBITS       = 64,
  parameter int DEADTIME_BITS = 4,
  parameter int HITCNT_BITS   = 16
) (
  input  logic                     clock,
  input  logic                     reset_i,
  input  logic [MXSBITS-1:0]       sbits_i,
  input  logic                     aligned_i,
  input  logic                     mask_i,
  input  logic [DEADTIME_BITS-1:0] deadtime_i,
  input  logic                     hitcnt_clear_i,
  output logic [MXSBITS-1:0]       sbits_o,
  output logic                     active_o,
  output logic [HITCNT_BITS-1:0]   hit_count_o
);
  logic [DEADTIME_BITS-1:0] cnt [MXSBITS];
  logic en;
  assign en = aligned_i && !mask_i;
  always_ff @(posedge clock or posedge reset_i)
    if (reset_i) begin
      active_o    <= 1'b0;
      sbits_o     <= '0;
      hit_count_o <= '0;
      for (int n = 0; n < MXSBITS; n++) cnt[n] <= '0;
    end else begin
      active_o    <= en;
      hit_count_o <= hitcnt_clear_i ? '0 : (|sbits_o && !(&hit_count_o)) ? hit_count_o + 1'b1 : hit_count_o;
      for (int n = 0; n < MXSBITS; n++) begin
        sbits_o[n] <= en && cnt[n] == '0 && sbits_i[n];
        cnt[n]     <= !en ? '0 : cnt[n] != '0 ? cnt[n] - 1'b1 : sbits_i[n] ? deadtime_i : '0;
      end
    end
endmodule
